// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end feeding the sequence detector one bit per clk.
// A single holding register behind the shifter lets back-to-back words stream without gap bits.
module serial_word_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             abort,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic [WIDTH-1:0] shifted;

  assign shifted    = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign din_ready  = !hold_full && !abort;
  assign sout_valid = (cnt != '0);
  assign sout_last  = (cnt == CW'(1));
  assign busy       = (cnt != '0) || hold_full;
  assign sout       = (cnt == '0) ? IDLE_BIT : (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);

  // Reload on the edge that ends the last bit (cnt==1) so words abut with no idle bit.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      sreg      <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else if (abort) begin
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      if (cnt <= CW'(1)) begin
        if (hold_full) begin
          sreg      <= hold;
          cnt       <= CW'(WIDTH);
          hold_full <= 1'b0;
        end else begin
          if (cnt == CW'(1)) sreg <= shifted;
          cnt <= '0;
        end
      end else begin
        sreg <= shifted;
        cnt  <= cnt - CW'(1);
      end
      // Only possible while hold is empty, so it never collides with the load above.
      if (din_valid && din_ready) begin
        hold      <= din;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: an MSB-first/idle-0 and an LSB-first/idle-1 build share stimulus.
// A bit-stream queue model predicts every output of both builds each cycle.
module tb_serial_word_feeder;

  logic       clk = 1'b0;
  logic       CLR = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       abort = 1'b0;
  logic       rdy_a, sout_a, sv_a, sl_a, busy_a;
  logic       rdy_b, sout_b, sv_b, sl_b, busy_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .CLR(CLR), .din(din), .din_valid(din_valid), .din_ready(rdy_a),
    .abort(abort), .sout(sout_a), .sout_valid(sv_a), .sout_last(sl_a), .busy(busy_a));

  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
    .clk(clk), .CLR(CLR), .din(din), .din_valid(din_valid), .din_ready(rdy_b),
    .abort(abort), .sout(sout_b), .sout_valid(sv_b), .sout_last(sl_b), .busy(busy_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each queue entry is {word, transmit position}; pending is the one-word buffer.
  logic [11:0] stream[$];
  logic [7:0]  pending[$];

  always @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      stream.delete();
      pending.delete();
    end else if (abort) begin
      stream.delete();
      pending.delete();
    end else begin
      automatic bit was_empty = (pending.size() == 0);
      automatic logic [7:0] w;
      if (stream.size() > 0) void'(stream.pop_front());
      if (stream.size() == 0 && pending.size() > 0) begin
        w = pending.pop_front();
        for (int i = 0; i < 8; i++) stream.push_back({w, 4'(i)});
      end
      if (was_empty && din_valid) pending.push_back(din);
    end
  end

  always @(negedge clk) begin
    automatic logic [7:0] w = '0;
    automatic int p = 0;
    automatic logic ev = (stream.size() > 0);
    automatic logic eb = (stream.size() > 0) || (pending.size() > 0);
    automatic logic er = (pending.size() == 0) && !abort;
    if (ev) begin
      w = stream[0][11:4];
      p = int'(stream[0][3:0]);
    end
    chk("a_valid", sv_a, ev);
    chk("a_sout", sout_a, ev ? w[7-p] : 1'b0);
    chk("a_last", sl_a, stream.size() == 1);
    chk("a_busy", busy_a, eb);
    chk("a_ready", rdy_a, er);
    chk("b_valid", sv_b, ev);
    chk("b_sout", sout_b, ev ? w[p] : 1'b1);
    chk("b_last", sl_b, stream.size() == 1);
    chk("b_busy", busy_b, eb);
    chk("b_ready", rdy_b, er);
  end

  // Capture of transmitted bits for hand-computed word checks.
  logic [31:0] cap_a, cap_b;
  int nva, nla, first_c, last_c, cyc;
  initial cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (sv_a) begin
      cap_a = {cap_a[30:0], sout_a};
      nva++;
      if (first_c < 0) first_c = cyc;
      last_c = cyc;
    end
    if (sl_a) nla++;
    if (sv_b) cap_b = {cap_b[30:0], sout_b};
  end

  task automatic cap_clear();
    cap_a = '0; cap_b = '0; nva = 0; nla = 0; first_c = -1; last_c = -1;
  endtask

  // Present a word until it is accepted; returns the number of edges it took.
  task automatic send(input logic [7:0] w, output int edges);
    logic r;
    din = w;
    din_valid = 1'b1;
    edges = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      r = rdy_a;
      @(posedge clk);
      #1;
      edges++;
      if (r) return;
    end
    chk("send_timeout", 32'(edges), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int e;
    int acc;
    logic r;
    cap_clear();
    #3;
    chk("rst_ready", rdy_a, 1'b1);
    chk("rst_valid", sv_a, 1'b0);
    chk("rst_sout_b", sout_b, 1'b1);
    chk("rst_busy", busy_a, 1'b0);
    #20 CLR = 1'b1;
    idle(2);

    // Single word, both bit orders.
    cap_clear();
    send(8'hD0, e);
    din_valid = 1'b0;
    idle(12);
    chk("single_a_bits", cap_a[7:0], 8'hD0);
    chk("single_b_bits", cap_b[7:0], 8'h0B);
    chk("single_nvalid", nva, 8);
    chk("single_span", last_c - first_c + 1, 8);
    chk("single_nlast", nla, 1);

    cap_clear();
    send(8'h0B, e);
    din_valid = 1'b0;
    idle(12);
    chk("lsb_b_bits", cap_b[7:0], 8'hD0);
    chk("lsb_a_bits", cap_a[7:0], 8'h0B);

    // Back-to-back: second word waits one edge for the hold register to drain.
    cap_clear();
    send(8'hD0, e);
    send(8'hB5, e);
    chk("b2b_accept_edges", e, 2);
    din_valid = 1'b0;
    idle(20);
    chk("b2b_a_bits", cap_a[15:0], 16'hD0B5);
    chk("b2b_b_bits", cap_b[15:0], 16'h0BAD);
    chk("b2b_nvalid", nva, 16);
    chk("b2b_span", last_c - first_c + 1, 16);
    chk("b2b_nlast", nla, 2);

    // Abort at bit 3 of 8'hFF with 8'h3C held.
    send(8'hFF, e);
    send(8'h3C, e);
    din_valid = 1'b0;
    idle(2);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_ready_low", rdy_a, 1'b0);
    @(posedge clk); #1;
    abort = 1'b0;
    cap_clear();
    @(negedge clk);
    chk("abort_valid", sv_a, 1'b0);
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_ready", rdy_a, 1'b1);
    chk("abort_sout_b", sout_b, 1'b1);
    idle(15);
    chk("abort_no_tx", nva, 0);

    // Async reset at bit 5, then a clean word.
    send(8'h5A, e);
    din_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3 CLR = 1'b0;
    #1;
    chk("arst_valid", sv_a, 1'b0);
    chk("arst_ready", rdy_a, 1'b1);
    chk("arst_sout_a", sout_a, 1'b0);
    chk("arst_sout_b", sout_b, 1'b1);
    chk("arst_busy", busy_b, 1'b0);
    #10 CLR = 1'b1;
    @(posedge clk); #1;
    cap_clear();
    send(8'hA5, e);
    din_valid = 1'b0;
    idle(12);
    chk("arst_word_a", cap_a[7:0], 8'hA5);
    chk("arst_word_b", cap_b[7:0], 8'hA5);
    chk("arst_nvalid", nva, 8);

    // Random traffic with backpressure and occasional abort; producer holds din until taken.
    acc = 0;
    din_valid = 1'b0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      r = rdy_a;
      @(posedge clk);
      #1;
      if (din_valid && r) acc++;
      if (!din_valid || r) begin
        din_valid = ($urandom_range(0, 9) < 7);
        din = 8'($urandom);
      end
      abort = ($urandom_range(0, 79) == 0);
    end
    abort = 1'b0;
    din_valid = 1'b0;
    idle(20);
    chk("rand_enough_words", acc >= 20, 1'b1);
    chk("rand_drained", busy_a, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
